// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and grant owner values.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arbState_t;

  localparam logic OWNER_INSTR = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

endpackage

// File: rtl/arbiter_grant.sv
// Combinational grant selection between instruction and data requesters.
// MEMORY_ARBITER_ROUND_ROBIN_EN selects round-robin on collisions; otherwise data wins.
module arbiter_grant
  import memory_arbiter_pkg::*;
(
  input  logic iRequest,
  input  logic dRequest,
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  input  logic lastGrant,
`endif
  output logic grant
);

  always_comb begin
    grant = OWNER_INSTR;
    if (iRequest && dRequest) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      grant = (lastGrant == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
`else
      grant = OWNER_DATA;
`endif
    end else if (dRequest) begin
      grant = OWNER_DATA;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port (instruction fill / data read-write) arbiter onto one backing memory.
// Optional round-robin collision handling via MEMORY_ARBITER_ROUND_ROBIN_EN.
//
// Handshake: requesters hold their enable and payload until their one-cycle ready
// pulse; the memory strobe is level-held through BUSY until memReady, which is
// only honoured in BUSY.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  iReadEnable,
  input  logic [ADDR_WIDTH-1:0] iAddress,
  output logic [DATA_WIDTH-1:0] iDataOut,
  output logic                  iReady,
  input  logic                  dReadEnable,
  input  logic                  dWriteEnable,
  input  logic [ADDR_WIDTH-1:0] dAddress,
  input  logic [DATA_WIDTH-1:0] dDataIn,
  output logic [DATA_WIDTH-1:0] dDataOut,
  output logic                  dReady,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memDataOut,
  output logic                  memReadEnable,
  output logic                  memWriteEnable,
  input  logic [DATA_WIDTH-1:0] memDataIn,
  input  logic                  memReady,
  output logic                  busy,
  output logic                  owner,
  output logic [1:0]            debugState
);

  arbState_t             state, nextState;
  logic                  ownerReg;
  logic                  isWrite;
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [DATA_WIDTH-1:0] wdataReg;
  logic [DATA_WIDTH-1:0] rdataReg;
  logic                  dRequest;
  logic                  anyRequest;
  logic                  grant;
  logic                  startTxn;

  assign dRequest   = dReadEnable | dWriteEnable;
  assign anyRequest = iReadEnable | dRequest;
  assign startTxn   = (state == IDLE) && anyRequest;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic lastGrant;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lastGrant <= OWNER_INSTR;
    end else if (startTxn) begin
      lastGrant <= grant;
    end
  end

  arbiter_grant u_grant (
    .iRequest  (iReadEnable),
    .dRequest  (dRequest),
    .lastGrant (lastGrant),
    .grant     (grant)
  );
`else
  arbiter_grant u_grant (
    .iRequest (iReadEnable),
    .dRequest (dRequest),
    .grant    (grant)
  );
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyRequest) nextState = BUSY;
      BUSY:    if (memReady) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // A data grant with both enables high is a write-back.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ownerReg <= OWNER_INSTR;
      isWrite  <= 1'b0;
      addrReg  <= '0;
      wdataReg <= '0;
      rdataReg <= '0;
    end else if (startTxn) begin
      ownerReg <= grant;
      isWrite  <= (grant == OWNER_DATA) && dWriteEnable;
      addrReg  <= (grant == OWNER_DATA) ? dAddress : iAddress;
      wdataReg <= dDataIn;
    end else if ((state == BUSY) && memReady && !isWrite) begin
      rdataReg <= memDataIn;
    end
  end

  always_comb begin
    memReadEnable  = 1'b0;
    memWriteEnable = 1'b0;
    iReady         = 1'b0;
    dReady         = 1'b0;
    if (state == BUSY) begin
      memReadEnable  = !isWrite;
      memWriteEnable = isWrite;
    end
    if (state == DONE) begin
      iReady = (ownerReg == OWNER_INSTR);
      dReady = (ownerReg == OWNER_DATA);
    end
  end

  assign memAddress = addrReg;
  assign memDataOut = wdataReg;
  assign iDataOut   = rdataReg;
  assign dDataOut   = rdataReg;
  assign busy       = (state != IDLE);
  assign owner      = ownerReg;
  assign debugState = state;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: the bench plays the backing memory and
// predicts grants, strobes and returned data from a transaction-level model.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetN;
  logic          iReadEnable;
  logic [AW-1:0] iAddress;
  logic [DW-1:0] iDataOut;
  logic          iReady;
  logic          dReadEnable;
  logic          dWriteEnable;
  logic [AW-1:0] dAddress;
  logic [DW-1:0] dDataIn;
  logic [DW-1:0] dDataOut;
  logic          dReady;
  logic [AW-1:0] memAddress;
  logic [DW-1:0] memDataOut;
  logic          memReadEnable;
  logic          memWriteEnable;
  logic [DW-1:0] memDataIn;
  logic          memReady;
  logic          busy;
  logic          owner;
  logic [1:0]    debugState;

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .iReadEnable    (iReadEnable),
    .iAddress       (iAddress),
    .iDataOut       (iDataOut),
    .iReady         (iReady),
    .dReadEnable    (dReadEnable),
    .dWriteEnable   (dWriteEnable),
    .dAddress       (dAddress),
    .dDataIn        (dDataIn),
    .dDataOut       (dDataOut),
    .dReady         (dReady),
    .memAddress     (memAddress),
    .memDataOut     (memDataOut),
    .memReadEnable  (memReadEnable),
    .memWriteEnable (memWriteEnable),
    .memDataIn      (memDataIn),
    .memReady       (memReady),
    .busy           (busy),
    .owner          (owner),
    .debugState     (debugState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  assert property (@(posedge clk) !(memReadEnable && memWriteEnable))
    else $error("FAIL strobe-exclusive: memReadEnable and memWriteEnable both high");

  // ---------------- model state / scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] expQ[$];
  logic [DW-1:0] memModel[logic [AW-1:0]];
  logic          lastGrant;

  function automatic logic [DW-1:0] memRead(input logic [AW-1:0] a);
    if (memModel.exists(a)) return memModel[a];
    return a ^ 32'hC0FF_EE00;
  endfunction

  // Who wins: a lone requester always; on collision data (fixed) or the side
  // that did not win last time (round-robin).
  function automatic logic modelOwner(input logic iReq, input logic dReq);
    if (iReq && dReq) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      return (lastGrant == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
`else
      return OWNER_DATA;
`endif
    end
    return dReq ? OWNER_DATA : OWNER_INSTR;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic dropRequests();
    iReadEnable  = 1'b0;
    dReadEnable  = 1'b0;
    dWriteEnable = 1'b0;
  endtask

  task automatic applyReset();
    resetN = 1'b0;
    dropRequests();
    memReady  = 1'b0;
    lastGrant = OWNER_INSTR;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  // Starts on a negedge with the DUT idle; ends on the negedge of the following idle cycle.
  task automatic runTxn(input logic iReq, input logic dRd, input logic dWr,
                        input logic [AW-1:0] iAddr, input logic [AW-1:0] dAddr,
                        input logic [DW-1:0] dData, input int lat, input logic keepReq,
                        input string name);
    logic          expOwner;
    logic          expWrite;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expData;
    logic [DW-1:0] gotData;
    int            waitCycles;
    iReadEnable  = iReq;
    iAddress     = iAddr;
    dReadEnable  = dRd;
    dWriteEnable = dWr;
    dAddress     = dAddr;
    dDataIn      = dData;
    expOwner  = modelOwner(iReq, dRd | dWr);
    lastGrant = expOwner;
    expWrite  = (expOwner == OWNER_DATA) && dWr;
    expAddr   = (expOwner == OWNER_DATA) ? dAddr : iAddr;
    if (expWrite) begin
      memModel[expAddr] = dData;
      expData = '0;
    end else begin
      expData = memRead(expAddr);
    end
    expQ.push_back(expData);

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, owner, memReadEnable, memWriteEnable, memAddress} !==
          {1'b1, expOwner, !expWrite, expWrite, expAddr}) begin
        errors++;
        $display("FAIL %s busy-cycle %0d: busy/owner/rd/wr=%b%b%b%b addr=%h, required %b%b%b%b addr=%h",
                 name, k, busy, owner, memReadEnable, memWriteEnable, memAddress,
                 1'b1, expOwner, !expWrite, expWrite, expAddr);
      end
      if (expWrite) begin
        checks++;
        if (memDataOut !== dData) begin
          errors++;
          $display("FAIL %s memDataOut: got %h, required %h", name, memDataOut, dData);
        end
      end
      if (k == lat) begin
        memReady  = 1'b1;
        memDataIn = expWrite ? DW'($urandom) : expData;
      end
    end

    @(negedge clk);
    memReady  = 1'b0;
    memDataIn = DW'($urandom);
    waitCycles = 0;
    while (!(iReady || dReady) && waitCycles < 8) begin
      @(negedge clk);
      waitCycles++;
    end
    checks++;
    if (waitCycles != 0) begin
      errors++;
      $display("FAIL %s ready-latency: ready came %0d cycles late (8 = never), required 0",
               name, waitCycles);
    end
    checks++;
    if ({iReady, dReady, memReadEnable, memWriteEnable} !==
        {expOwner == OWNER_INSTR, expOwner == OWNER_DATA, 2'b00}) begin
      errors++;
      $display("FAIL %s done-outputs: iReady/dReady/rd/wr=%b%b%b%b, required %b%b00",
               name, iReady, dReady, memReadEnable, memWriteEnable,
               expOwner == OWNER_INSTR, expOwner == OWNER_DATA);
    end
    expData = expQ.pop_front();
    if (!expWrite) begin
      gotData = (expOwner == OWNER_DATA) ? dDataOut : iDataOut;
      checks++;
      if (gotData !== expData) begin
        errors++;
        $display("FAIL %s read-data: got %h, required %h", name, gotData, expData);
      end
    end
    if (!keepReq) dropRequests();

    @(negedge clk);
    checks++;
    if ({iReady, dReady, busy} !== 3'b000) begin
      errors++;
      $display("FAIL %s after-done: iReady/dReady/busy=%b%b%b, required 000",
               name, iReady, dReady, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetN = 1'b0;
    dropRequests();
    memReady  = 1'b0;
    lastGrant = OWNER_INSTR;
    @(negedge clk);
    checks++;
    if ({memReadEnable, memWriteEnable, iReady, dReady, busy, owner, iDataOut, dDataOut, debugState} !==
        {6'b0, {DW{1'b0}}, {DW{1'b0}}, IDLE}) begin
      errors++;
      $display("FAIL reset-state: rd/wr/iR/dR/busy/owner=%b%b%b%b%b%b iData=%h dData=%h state=%0d, required all zero",
               memReadEnable, memWriteEnable, iReady, dReady, busy, owner, iDataOut, dDataOut, debugState);
    end
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_instr_read();
    memModel[32'h0000_0040] = 32'hDEAD_BEEF;
    runTxn(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 1, 1'b0, "instr_read");
  endtask

  task automatic test_data_write();
    runTxn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0100, 32'h1234_5678, 4, 1'b0, "data_write");
    runTxn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 32'h0, 2, 1'b0, "data_readback");
  endtask

  task automatic test_simultaneous();
    applyReset();
    runTxn(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0300, 32'h0, 1, 1'b0, "collide_1");
    runTxn(1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'h0000_0304, 32'h0, 2, 1'b0, "collide_2");
  endtask

  task automatic test_both_enables();
    runTxn(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0400, 32'hA5A5_0F0F, 3, 1'b0, "both_enables");
  endtask

  task automatic test_back_to_back();
    runTxn(1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0, 32'h0, 2, 1'b1, "hold_first");
    runTxn(1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0, 32'h0, 1, 1'b0, "hold_second");
  endtask

  task automatic test_reset_mid_busy();
    dReadEnable = 1'b1;
    dAddress    = 32'h0000_0600;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b0;
    dropRequests();
    lastGrant = OWNER_INSTR;
    #1;
    checks++;
    if ({memReadEnable, memWriteEnable, iReady, dReady, busy, owner, iDataOut, dDataOut} !==
        {6'b0, {DW{1'b0}}, {DW{1'b0}}}) begin
      errors++;
      $display("FAIL mid-busy-reset: rd/wr/iR/dR/busy/owner=%b%b%b%b%b%b iData=%h dData=%h, required all zero",
               memReadEnable, memWriteEnable, iReady, dReady, busy, owner, iDataOut, dDataOut);
    end
    @(negedge clk);
    resetN    = 1'b1;
    memReady  = 1'b1;
    memDataIn = 32'h5555_AAAA;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      memReady = 1'b0;
      checks++;
      if ({iReady, dReady, busy, memReadEnable, iDataOut, dDataOut} !== {4'b0, {DW{1'b0}}, {DW{1'b0}}}) begin
        errors++;
        $display("FAIL late-memready-%0d: iR/dR/busy/rd=%b%b%b%b iData=%h dData=%h, required zeros",
                 k, iReady, dReady, busy, memReadEnable, iDataOut, dDataOut);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    for (int n = 0; n < 30; n++) begin
      r = 3'($urandom_range(1, 7));
      runTxn(r[0], r[1], r[2],
             AW'($urandom_range(0, 15)) << 2, AW'($urandom_range(0, 15)) << 2,
             DW'($urandom), $urandom_range(1, 4), 1'b0, "random");
    end
  endtask

  initial begin
    iAddress  = '0;
    dAddress  = '0;
    dDataIn   = '0;
    memDataIn = '0;
    test_reset();
    test_instr_read();
    test_data_write();
    test_simultaneous();
    test_both_enables();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
